mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Multi-requester front end for the single-port `memory` model. It clears the memory after reset, then grants one requester per cycle round-robin and drives the memory's `addr`/`wr_en`/`rd_en`/`wdata` from registered outputs. Read data is routed back to the requester that issued the read. It sits between N bus-side clients and one `memory` instance in the test DUT.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2)
- `ADDR_WIDTH`, 2: memory address width
- `DATA_WIDTH`, 8: memory data width

- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester grant/accept; handshake = valid & ready
- `req_wr`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data
- `rsp_valid`  out  NUM_REQ  one-cycle read-response strobe to the owning requester
- `rsp_rdata`  out  DATA_WIDTH  read data, valid while any `rsp_valid` bit is high
- `init_done`  out  1  memory clear complete
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`
- `mem_wr_en`  out  1  to memory `wr_en`
- `mem_rd_en`  out  1  to memory `rd_en`
- `mem_wdata`  out  DATA_WIDTH  to memory `wdata`
- `mem_rdata`  in  DATA_WIDTH  from memory `rdata`

## Operation
- FSM states: INIT, RUN. Reset enters INIT.
- INIT: a clear counter walks 0 … 2**ADDR_WIDTH−1, issuing one write of 0 per cycle. `req_ready` is all 0. After the last address is issued, the FSM goes to RUN and `init_done` goes to 1.
- RUN: exactly one `req_ready` bit is high, at the first `req_valid` requester found searching from the round-robin pointer. `req_ready` is combinational from `req_valid`, the pointer and the state. No valid request means no ready.
- Pointer: on a grant to requester i, the pointer becomes (i+1) mod NUM_REQ. With no grant it holds.
- Handshake in cycle C loads the issue stage at the end of C: `mem_addr`, `mem_wdata`, `mem_wr_en = req_wr`, `mem_rd_en = !req_wr`, and owner id. With no handshake, `mem_wr_en` and `mem_rd_en` load 0.
- Response stage: for an issued read, record {valid, owner} one cycle later. In the following cycle `rsp_valid[owner] = 1` and `rsp_rdata = mem_rdata` (pass-through).
- Writes produce no response. Responses cannot be back-pressured; requesters must sink them.
- `rsp_rdata` outside a response is don't-care, but is driven as `mem_rdata`.

## Timing
- Reset values: `req_ready = 0`, `rsp_valid = 0`, `init_done = 0`, `mem_addr = 0`, `mem_wr_en = 0`, `mem_rd_en = 0`, `mem_wdata = 0`, pointer = 0, clear counter = 0.
- INIT lasts exactly 2**ADDR_WIDTH cycles after the first edge with `reset_n` high.
  - `mem_wr_en = 1` with address k during INIT cycle k+1.
  - `init_done` and RUN begin in the cycle after address 2**ADDR_WIDTH−1 is presented.
- Read latency: handshake in cycle C → memory samples at end of C+1 → `rsp_valid` in cycle C+2.
- Throughput: one access per cycle, back-to-back reads or writes, with no bubbles.
- Read-after-write to the same address in consecutive cycles (write at C, read at C+1) returns the new data. The memory commits the write before the read samples, so no forwarding is needed.
- Reset asserted mid-operation: all outputs clear asynchronously, pending responses are dropped and never delivered, and INIT reruns after release.
- Clear counter is ADDR_WIDTH+1 bits so that termination is detected without wrap ambiguity.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: the pointer logic is removed and the lowest-index valid requester always wins. Starvation is allowed.
- Undefined (default): round-robin as above.

## Structure
- `mem_arb_pkg`: state enum (`ST_INIT`, `ST_RUN`) and the default width constants.
- One sub-module, `mem_arb_rr`: parameterised NUM_REQ round-robin picker.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - The macro selects priority inside it.
- Top level holds the FSM, clear counter, issue stage and response stage.

## Test plan
(NUM_REQ=2, ADDR_WIDTH=2, DATA_WIDTH=8)
- Release `reset_n` → `mem_wr_en=1`, `mem_wdata=0x00` for addr 0,1,2,3 on four consecutive cycles; `req_ready=0` throughout; `init_done=1` in the fifth cycle.
- Req0 writes 0xA5 to addr 2, then req0 reads addr 2 → `rsp_valid=2'b01` two cycles after the read handshake, `rsp_rdata=0xA5`.
- Req1 writes 0x3C to addr 1 in cycle C, req0 reads addr 1 in cycle C+1 → `rsp_valid[0]` in C+3 with 0x3C.
- Both requesters hold reads valid continuously → grants alternate 0,1,0,1 and responses alternate owners. With `MEM_ARB_FIXED_PRIO_EN`, req0 is granted every cycle and `req_ready[1]` stays 0.
- Read of addr 3 right after INIT, never written → `rsp_rdata=0x00`.
- Pull `reset_n` low one cycle after a read handshake → `rsp_valid` never pulses, `init_done` drops immediately, INIT reruns after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN (fixed priority picker).
package mem_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin picker: first request at or after ptr wins.
// MEM_ARB_FIXED_PRIO_EN makes the lowest index always win.
import mem_arb_pkg::*;

module mem_arb_rr #(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  int   j;
  logic found;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // scan requesters in priority order, keep the first one
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (int'(ptr) + k) % NUM_REQ;
`endif
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-requester front end for a single-port memory.
// Build option: MEM_ARB_FIXED_PRIO_EN (fixed priority).
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          init_done,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_wr_en,
  output logic                          mem_rd_en,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int IW = idx_w(NUM_REQ);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [IW-1:0]         ptr_q, gnt_idx;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         rsp_owner_q;
  logic                  rsp_pend_q;
  logic [NUM_REQ-1:0]    grant;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  wr_d, rd_d;

  mem_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (state_q == ST_RUN),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign req_ready = grant;
  assign hs        = |grant;
  assign init_done = (state_q == ST_RUN);
  assign rsp_rdata = mem_rdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  // advance past the requester just served
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (hs) begin
      if (int'(gnt_idx) == NUM_REQ - 1) ptr_q <= '0;
      else ptr_q <= gnt_idx + IW'(1);
    end
  end
`endif

  // state and clear counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and issue-stage inputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    owner_d = owner_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q[ADDR_WIDTH]) begin
          state_d = ST_RUN;
        end else begin
          wr_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = '0;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (hs) begin
          addr_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
          wr_d    = req_wr[gnt_idx];
          rd_d    = !req_wr[gnt_idx];
          owner_d = gnt_idx;
        end
      end
    endcase
  end

  // issue stage drives the memory
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      owner_q   <= '0;
    end else begin
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_wr_en <= wr_d;
      mem_rd_en <= rd_d;
      owner_q   <= owner_d;
    end
  end

  // response stage tracks the read the memory is sampling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= '0;
    end else begin
      rsp_pend_q  <= mem_rd_en;
      rsp_owner_q <= owner_q;
    end
  end

  // strobe the owning requester
  always_comb begin
    rsp_valid = '0;
    if (rsp_pend_q) rsp_valid[rsp_owner_q] = 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural memory.
// Honours MEM_ARB_FIXED_PRIO_EN in its reference model.
module tb_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int          cyc;
    int          owner;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            init_done;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_en;
  logic            mem_rd_en;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  logic [DW-1:0] phys[DEPTH];
  logic [DW-1:0] ref_mem[DEPTH];
  exp_t          sb[$];
  int            cyc = 0;
  int            ptr = 0;
  bit            model_run = 0;
  int            vectors = 0;
  int            miscompares = 0;

  mem_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // single-port synchronous memory the arbiter drives
  always @(posedge clk) begin
    if (mem_wr_en) phys[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= phys[mem_addr];
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               name, cyc, got, exp);
    end
  endtask

  // response monitor: pops the scoreboard on due cycles
  initial begin
    exp_t          e;
    logic [N-1:0]  exp_v;
    logic [DW-1:0] exp_d;
    bit            chk_d;
    forever begin
      @(negedge clk);
      exp_v = '0;
      exp_d = '0;
      chk_d = 0;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL rsp_missed cyc=%0d due=%0d", cyc, e.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        exp_v[e.owner] = 1'b1;
        exp_d = e.data;
        chk_d = 1;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (chk_d) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
    end
  end

  task automatic cycle(input logic [N-1:0]    v,
                       input logic [N-1:0]    w,
                       input logic [N*AW-1:0] a,
                       input logic [N*DW-1:0] d);
    int           win;
    logic [N-1:0] er;
    logic [AW-1:0] ad;
    exp_t         e;
    @(posedge clk);
    cyc++;
    #1;
    req_valid = v;
    req_wr    = w;
    req_addr  = a;
    req_wdata = d;
    #1;
    win = -1;
    er  = '0;
    if (model_run) begin
      for (int k = 0; k < N; k++) begin
        int j;
`ifdef MEM_ARB_FIXED_PRIO_EN
        j = k;
`else
        j = (ptr + k) % N;
`endif
        if (win < 0 && v[j]) win = j;
      end
    end
    if (win >= 0) er[win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (win >= 0) begin
      ad = a[win*AW +: AW];
      if (w[win]) begin
        ref_mem[ad] = d[win*DW +: DW];
      end else begin
        e.cyc   = cyc + 2;
        e.owner = win;
        e.data  = ref_mem[ad];
        sb.push_back(e);
      end
      ptr = (win + 1) % N;
    end
  endtask

  task automatic check_init();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    req_valid = '1;
    req_wr    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk);
      cyc++;
      #2;
      chk("init_wr_en", 32'(mem_wr_en), 32'd1);
      chk("init_addr", 32'(mem_addr), 32'(k));
      chk("init_wdata", 32'(mem_wdata), 32'd0);
      chk("init_ready", 32'(req_ready), 32'd0);
      chk("init_busy", 32'(init_done), 32'd0);
    end
    @(posedge clk);
    cyc++;
    #1;
    req_valid = '0;
    #1;
    chk("init_done", 32'(init_done), 32'd1);
    chk("run_wr_en", 32'(mem_wr_en), 32'd0);
    model_run = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, '0);
  endtask

  initial begin
    logic [N-1:0]    rv, rw;
    logic [N*AW-1:0] ra;
    logic [N*DW-1:0] rd;
    for (int i = 0; i < DEPTH; i++) phys[i] = 8'(($urandom % 255) + 1);

    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check_init();

    // unwritten address reads as cleared
    cycle(2'b01, 2'b00, {2'd0, 2'd3}, '0);
    // write then read back on requester 0
    cycle(2'b01, 2'b01, {2'd0, 2'd2}, {8'h00, 8'hA5});
    cycle(2'b01, 2'b00, {2'd0, 2'd2}, '0);
    idle(2);
    // read-after-write across requesters
    cycle(2'b10, 2'b10, {2'd1, 2'd0}, {8'h3C, 8'h00});
    cycle(2'b01, 2'b00, {2'd0, 2'd1}, '0);
    idle(2);
    // contention: both reading continuously
    repeat (4) cycle(2'b11, 2'b00, {2'd1, 2'd2}, '0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      rv = N'($urandom);
      rw = N'($urandom);
      ra = (N*AW)'($urandom);
      rd = (N*DW)'($urandom);
      cycle(rv, rw, ra, rd);
    end
    idle(3);

    // reset right after a read handshake
    cycle(2'b01, 2'b00, {2'd0, 2'd2}, '0);
    @(posedge clk);
    cyc++;
    #1;
    req_valid = '0;
    reset_n   = 1'b0;
    sb.delete();
    ptr       = 0;
    model_run = 0;
    #1;
    chk("mid_rst_done", 32'(init_done), 32'd0);
    chk("mid_rst_rd", 32'(mem_rd_en), 32'd0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    check_init();

    for (int i = 0; i < 100; i++) begin
      rv = N'($urandom);
      rw = N'($urandom);
      ra = (N*AW)'($urandom);
      rd = (N*DW)'($urandom);
      cycle(rv, rw, ra, rd);
    end
    idle(4);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
